// File: rtl/bg_pkg.sv
// Shared constants, packet layout and width helper for the background line sequencer.
package bg_pkg;

  localparam int BG_NUM_BG   = 4;
  localparam int BG_HTOTAL   = 308;
  localparam int BG_VTOTAL   = 228;
  localparam int BG_HVISIBLE = 240;
  localparam int BG_VVISIBLE = 160;
  localparam int BG_PKT_W    = 20;
  localparam int COL_W       = 9;
  localparam int ROW_W       = 8;

  // A single layer still needs a one-bit bgno field.
  function automatic int bgno_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [COL_W-1:0]             col;
    logic [bgno_w(BG_NUM_BG)-1:0] bgno;
    logic [BG_PKT_W-1:0]          data;
  } bg_pkt_t;

endpackage

// File: rtl/bg_credit_fifo.sv
// Packet FIFO with an exported occupancy count used for credit accounting upstream.
module bg_credit_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && valid;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bg_line_sequencer.sv
// Walks (row, col, bgno) slots, issues VRAM fetches under FIFO credit and queues
// the returned data as {col, bgno, data} packets.
module bg_line_sequencer
  import bg_pkg::*;
#(
  parameter int  NUM_BG     = BG_NUM_BG,
  parameter int  HTOTAL     = BG_HTOTAL,
  parameter int  VTOTAL     = BG_VTOTAL,
  parameter int  VRAM_LAT   = 1,
  parameter int  FIFO_DEPTH = 4,
  parameter int  PKT_W      = BG_PKT_W,
  localparam int BW         = bgno_w(NUM_BG),
  localparam int OUT_W      = PKT_W + BW + COL_W
) (
  input  logic              clock,
  input  logic              rst_b,
  input  logic              run,
  input  logic [NUM_BG-1:0] layer_en,
  output logic              req_valid,
  output logic [COL_W-1:0]  req_col,
  output logic [ROW_W-1:0]  req_row,
  output logic [BW-1:0]     req_bgno,
  input  logic [PKT_W-1:0]  vram_data,
  output logic [OUT_W-1:0]  pkt,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic              start_row,
  output logic              new_frame
);

  localparam int TAG_W = COL_W + BW + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(VRAM_LAT + 1);
  localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;
  logic [BW-1:0]       bgno;
  logic [INF_W-1:0]    inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic                has_credit;
  logic                advance;
  logic                slot_en;
  logic                last_bg;
  logic                last_col;
  logic                last_row;

  logic [VRAM_LAT-1:0] pipe_vld;
  logic [TAG_W-1:0]    pipe_tag [VRAM_LAT];
  logic [TAG_W-1:0]    exit_tag;
  logic                exit_vld;
  logic [COL_W-1:0]    exit_col;
  logic [BW-1:0]       exit_bgno;
  logic                exit_en;
  logic [OUT_W-1:0]    fifo_wdata;

  // Every slot already issued or queued holds a credit, so the FIFO can never overflow.
  assign has_credit = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(FIFO_DEPTH);
  assign advance    = rst_b && run && has_credit;
  assign slot_en    = layer_en[bgno];

  assign last_bg  = (bgno == BW'(NUM_BG - 1));
  assign last_col = (col == COL_W'(HTOTAL - 1));
  assign last_row = (row == ROW_W'(VTOTAL - 1));

  assign req_valid = advance && slot_en;
  assign req_col   = col;
  assign req_row   = row;
  assign req_bgno  = bgno;
  assign start_row = advance && last_bg && last_col;
  assign new_frame = start_row && last_row;

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      row  <= '0;
      col  <= '0;
      bgno <= '0;
    end else if (advance) begin
      if (last_bg) begin
        bgno <= '0;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        bgno <= bgno + 1'b1;
      end
    end
  end

  // Tag pipeline mirrors the VRAM latency and never stalls; credit keeps the FIFO room.
  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      pipe_vld <= '0;
      for (int i = 0; i < VRAM_LAT; i++) pipe_tag[i] <= '0;
      inflight <= '0;
    end else begin
      pipe_vld[0] <= advance;
      pipe_tag[0] <= {col, bgno, slot_en};
      for (int i = 1; i < VRAM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      inflight <= inflight + INF_W'(advance) - INF_W'(exit_vld);
    end
  end

  assign exit_vld   = pipe_vld[VRAM_LAT-1];
  assign exit_tag   = pipe_tag[VRAM_LAT-1];
  assign exit_col   = exit_tag[TAG_W-1 -: COL_W];
  assign exit_bgno  = exit_tag[BW:1];
  assign exit_en    = exit_tag[0];
  assign fifo_wdata = {exit_col, exit_bgno, exit_en ? vram_data : {PKT_W{1'b0}}};

  bg_credit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clock (clock),
    .rst_b (rst_b),
    .push  (exit_vld),
    .wdata (fifo_wdata),
    .pop   (pkt_ready),
    .rdata (pkt),
    .valid (pkt_valid),
    .count (fifo_count)
  );

endmodule
